alu_mdu_seq: RTL and testbench

- Parametrised, sequential successor to the combinational RV32I ALU.
- Executes the base integer ops (add/sub/and/or/xor/slt/sll/srl/sra) plus the RV32M multiply/divide set.
- Uses an XLEN-wide datapath with valid/ready handshakes on both sides.
- Sits in the EX stage; the pipeline stalls while in_ready=0.
- Multiply and divide are iterative (one bit per cycle); base ops complete in one cycle.

---
 rtl/alu_mdu_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_mdu_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_seq.sv
// rtl/alu_mdu_seq.sv - sequential RV32I ALU plus RV32M multiply/divide unit
// Base ops finish in one cycle; mul/div iterate one bit per cycle on magnitudes.
module alu_mdu_seq #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            N,
  output logic            V,
  output logic            C,
  output logic            busy
);

  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t              state;
  logic [SHW-1:0]      cnt;
  logic [2*XLEN-1:0]   p;
  logic [XLEN-1:0]     ma;
  logic [1:0]          mop;
  logic                neg_q;
  logic                neg_r;

  // Base-op datapath, evaluated straight from the inputs at accept time
  logic                sub_like;
  logic [XLEN-1:0]     bx;
  logic [XLEN:0]       sum_ext;
  logic [SHW-1:0]      sh;
  logic [XLEN-1:0]     base_res;
  logic                base_v;
  logic                base_c;

  always_comb begin
    sub_like = (op == 5'b00001) || (op == 5'b00101);
    bx       = sub_like ? ~B : B;
    sum_ext  = {1'b0, A} + {1'b0, bx} + {{XLEN{1'b0}}, sub_like};
    sh       = B[SHW-1:0];
    base_v   = 1'b0;
    base_c   = 1'b0;
    case (op)
      5'b00000, 5'b00001: begin
        base_res = sum_ext[XLEN-1:0];
        base_v   = (A[XLEN-1] ^ sum_ext[XLEN-1]) & ~(op[0] ^ A[XLEN-1] ^ B[XLEN-1]);
        base_c   = sum_ext[XLEN];
      end
      5'b00010: base_res = A & B;
      5'b00011: base_res = A | B;
      5'b00100: base_res = A ^ B;
      5'b00101: base_res = {{(XLEN-1){1'b0}}, sum_ext[XLEN-1]};
      5'b00110: base_res = A << sh;
      5'b01001: base_res = A >> sh;
      5'b01010: base_res = $signed(A) >>> sh;
      default:  base_res = '0;
    endcase
  end

  // Operand magnitudes and sign tracking for the iterative units
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;

  always_comb begin
    if (op[2]) begin
      sa = ~op[0] & A[XLEN-1];
      sb = ~op[0] & B[XLEN-1];
    end else begin
      sa = (op[1:0] != 2'b11) & A[XLEN-1];
      sb = ~op[1] & B[XLEN-1];
    end
    mag_a    = sa ? -A : A;
    mag_b    = sb ? -B : B;
    div_zero = (B == '0);
    div_ovf  = ~op[0] & (A == {1'b1, {(XLEN-1){1'b0}}}) & (&B);
  end

  // One shift-add multiply step and one restoring divide step on p
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] p_mul;
  logic [2*XLEN-1:0] prod;
  logic [XLEN:0]     r_sh;
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] p_div;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;

  always_comb begin
    mul_sum = p[0] ? ({1'b0, p[2*XLEN-1:XLEN]} + {1'b0, ma}) : {1'b0, p[2*XLEN-1:XLEN]};
    p_mul   = {mul_sum, p[XLEN-1:1]};
    prod    = neg_q ? -p_mul : p_mul;
    r_sh    = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    trial   = r_sh - {1'b0, ma};
    if (!trial[XLEN])
      p_div = {trial[XLEN-1:0], p[XLEN-2:0], 1'b1};
    else
      p_div = {r_sh[XLEN-1:0], p[XLEN-2:0], 1'b0};
    quo = neg_q ? -p_div[XLEN-1:0] : p_div[XLEN-1:0];
    rem = neg_r ? -p_div[2*XLEN-1:XLEN] : p_div[2*XLEN-1:XLEN];
  end

  // Single point where a finished result and its flags are produced
  logic            load_res;
  logic [XLEN-1:0] res_d;
  logic            v_d;
  logic            c_d;

  always_comb begin
    load_res = 1'b0;
    res_d    = '0;
    v_d      = 1'b0;
    c_d      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!op[4]) begin
            load_res = 1'b1;
            res_d    = base_res;
            v_d      = base_v;
            c_d      = base_c;
          end else if (op[3]) begin
            load_res = 1'b1;
          end else if (op[2] && div_zero) begin
            load_res = 1'b1;
            res_d    = op[1] ? A : '1;
          end else if (op[2] && div_ovf) begin
            load_res = 1'b1;
            res_d    = op[1] ? '0 : A;
          end
        end
      end
      MUL: begin
        if (cnt == LAST) begin
          load_res = 1'b1;
          res_d    = (mop == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
      end
      DIV: begin
        if (cnt == LAST) begin
          load_res = 1'b1;
          res_d    = mop[1] ? rem : quo;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      Result    <= '0;
      Zero      <= 1'b1;
      N         <= 1'b0;
      V         <= 1'b0;
      C         <= 1'b0;
      cnt       <= '0;
      p         <= '0;
      ma        <= '0;
      mop       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      if (load_res) begin
        Result <= res_d;
        Zero   <= ~|res_d;
        N      <= res_d[XLEN-1];
        V      <= v_d;
        C      <= c_d;
      end
      case (state)
        IDLE: begin
          if (in_valid) begin
            mop      <= op[1:0];
            cnt      <= '0;
            neg_q    <= sa ^ sb;
            neg_r    <= sa;
            in_ready <= 1'b0;
            if (load_res) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else if (op[2]) begin
              state <= DIV;
              busy  <= 1'b1;
              p     <= {{XLEN{1'b0}}, mag_a};
              ma    <= mag_b;
            end else begin
              state <= MUL;
              busy  <= 1'b1;
              p     <= {{XLEN{1'b0}}, mag_b};
              ma    <= mag_a;
            end
          end
        end
        MUL, DIV: begin
          p   <= (state == MUL) ? p_mul : p_div;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// tb/tb_alu_mdu_seq.sv - directed self-checking bench for alu_mdu_seq
// Each task drives one scenario and compares against hand-computed values.
module tb_alu_mdu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        n;
  logic        v;
  logic        c;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_mdu_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .Result(result),
    .Zero(zero), .N(n), .V(v), .C(c), .busy(busy)
  );

  always #5 clk = ~clk;

  // Present one op, then count edges (accept edge = 1) until out_valid
  task automatic issue_wait(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                            output int lat, output int busy_cyc);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    busy_cyc = 0;
    while (!out_valid && lat < 200) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_hs got in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 00000000", result); end
    tests++; if ({zero, n, v, c} !== 4'b1000) begin fails++; $display("FAIL reset_flags got ZNVC=%b want 1000", {zero, n, v, c}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    int lat, bc;
    issue_wait(5'b00000, 32'h7FFF_FFFF, 32'h1, lat, bc);
    tests++; if (lat !== 1) begin fails++; $display("FAIL add_latency got %0d want 1", lat); end
    tests++; if (result !== 32'h8000_0000) begin fails++; $display("FAIL add_result got %h want 80000000", result); end
    tests++; if ({zero, n, v, c} !== 4'b0110) begin fails++; $display("FAIL add_flags got ZNVC=%b want 0110", {zero, n, v, c}); end
    take();
    issue_wait(5'b00001, 32'h5, 32'h5, lat, bc);
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL sub_result got %h want 00000000", result); end
    tests++; if ({zero, n, v, c} !== 4'b1001) begin fails++; $display("FAIL sub_flags got ZNVC=%b want 1001", {zero, n, v, c}); end
    take();
  endtask

  task automatic test_logic_shift();
    logic [4:0]  ops [8] = '{5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01001, 5'b01010, 5'b00111};
    logic [31:0] xa  [8] = '{32'hF0F0_1234, 32'hF000_0000, 32'hFFFF_0000, 32'h3, 32'h1, 32'h8000_0000, 32'h8000_0000, 32'h1234};
    logic [31:0] xb  [8] = '{32'h0FF0_00FF, 32'h0000_000F, 32'h0F0F_0F0F, 32'h5, 32'h0000_0021, 32'h4, 32'h0000_0024, 32'h1};
    logic [31:0] exp [8] = '{32'h00F0_0034, 32'hF000_000F, 32'hF0F0_0F0F, 32'h1, 32'h2, 32'h0800_0000, 32'hF800_0000, 32'h0};
    int lat, bc;
    for (int i = 0; i < 8; i++) begin
      issue_wait(ops[i], xa[i], xb[i], lat, bc);
      tests++; if (result !== exp[i] || lat !== 1) begin fails++; $display("FAIL base_op_%b got %h lat %0d want %h lat 1", ops[i], result, lat, exp[i]); end
      tests++; if (v !== 1'b0 || c !== 1'b0 || zero !== (exp[i] == 32'h0)) begin fails++; $display("FAIL base_flags_%b got Z=%b V=%b C=%b want Z=%b V=0 C=0", ops[i], zero, v, c, exp[i] == 32'h0); end
      take();
    end
  endtask

  task automatic test_mul();
    logic [4:0]  ops [4] = '{5'b10001, 5'b10000, 5'b10011, 5'b10010};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFF};
    int lat, bc;
    for (int i = 0; i < 4; i++) begin
      issue_wait(ops[i], 32'hFFFF_FFFE, 32'h3, lat, bc);
      tests++; if (lat !== 33 || bc !== 32) begin fails++; $display("FAIL mul_timing_%b got lat %0d busy %0d want 33 32", ops[i], lat, bc); end
      tests++; if (result !== exp[i]) begin fails++; $display("FAIL mul_result_%b got %h want %h", ops[i], result, exp[i]); end
      take();
    end
  endtask

  task automatic test_div();
    logic [4:0]  ops [8] = '{5'b10100, 5'b10110, 5'b10101, 5'b10100, 5'b10111, 5'b10101, 5'b10111, 5'b10110};
    logic [31:0] xa  [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h7, 32'h8000_0000, 32'h7, 32'd100, 32'd100, 32'h8000_0000};
    logic [31:0] xb  [8] = '{32'h2, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'd7, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] exp [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7, 32'd14, 32'd2, 32'h0};
    int          el  [8] = '{33, 33, 1, 1, 1, 33, 33, 1};
    int lat, bc;
    for (int i = 0; i < 8; i++) begin
      issue_wait(ops[i], xa[i], xb[i], lat, bc);
      tests++; if (result !== exp[i] || lat !== el[i]) begin fails++; $display("FAIL div_case_%0d got %h lat %0d want %h lat %0d", i, result, lat, exp[i], el[i]); end
      take();
    end
  endtask

  task automatic test_hold();
    int lat, bc;
    issue_wait(5'b00000, 32'h1, 32'h2, lat, bc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++; if (result !== 32'h3 || in_ready !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL hold_cycle_%0d got %h in_ready=%b out_valid=%b want 00000003 0 1", i, result, in_ready, out_valid); end
    end
    take();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL hold_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    @(negedge clk);
    op = 5'b10001; a = 32'hFFFF_FFFE; b = 32'h3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midreset_pre got busy=%b want 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midreset_hs got in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
    tests++; if (result !== 32'h0 || zero !== 1'b1) begin fails++; $display("FAIL midreset_result got %h Z=%b want 00000000 1", result, zero); end
    @(negedge clk);
    rst = 1'b0;
    issue_wait(5'b00000, 32'h2, 32'h3, lat, bc);
    tests++; if (result !== 32'h5 || lat !== 1) begin fails++; $display("FAIL after_reset_add got %h lat %0d want 00000005 lat 1", result, lat); end
    take();
  endtask

  task automatic test_unused_m();
    int lat, bc;
    issue_wait(5'b11010, 32'h1234, 32'h5678, lat, bc);
    tests++; if (result !== 32'h0 || zero !== 1'b1 || lat !== 1) begin fails++; $display("FAIL unused_m got %h Z=%b lat %0d want 00000000 1 lat 1", result, zero, lat); end
    take();
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic_shift();
    test_mul();
    test_div();
    test_unused_m();
    test_hold();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
